forwarding_hazard_unit: RTL and testbench

- Producer side of the EXE-stage forwarding interface. Drives memAdelant_rs/rt, wbAdelant_rs/rt, memAdeltantado and wbAdelantado into the execute stage.
- Tracks destination register, RegWrite and MemRead of the instructions in EX, MEM and WB. Detects load-use hazards.
- Generates the PC/IF-ID hold and the ID/EX bubble for a configurable number of cycles.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS core.

---
 rtl/forwarding_hazard_unit_pkg.sv | 15 +
 rtl/forwarding_hazard_unit_if.sv | 41 ++++
 rtl/forwarding_hazard_unit_stall_fsm.sv | 58 +++++
 rtl/forwarding_hazard_unit.sv | 84 ++++++++
 tb/tb_forwarding_hazard_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared widths, register-zero constant, stall FSM encoding and the
// forwarding match helper for the EXE-stage forwarding/hazard unit.
package forwarding_hazard_unit_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} stall_state_e;

   // A producer matches a source when it writes, is not $0 and names that source.
   function automatic logic fwd_hit(input logic rw, input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] src);
      return rw && (dest != REG_ZERO) && (dest == src);
   endfunction
endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit; master is the unit itself.
interface forwarding_hazard_unit_if
   import forwarding_hazard_unit_pkg::*;
#(parameter int CNT_W = 16);
   logic              freeze;
   logic              id_valid;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              id_uses_rt;
   logic [REG_W-1:0]  ex_dest;
   logic              ex_regwrite;
   logic              ex_memread;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] wb_data;
   logic              memAdelant_rs;
   logic              memAdelant_rt;
   logic              wbAdelant_rs;
   logic              wbAdelant_rt;
   logic [DATA_W-1:0] memAdeltantado;
   logic [DATA_W-1:0] wbAdelantado;
   logic              stall;
   logic              idex_flush;
   logic [CNT_W-1:0]  fwd_count;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      input  freeze, id_valid, id_rs, id_rt, id_uses_rt,
             ex_dest, ex_regwrite, ex_memread, ex_alu_result, wb_data,
      output memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt,
             memAdeltantado, wbAdelantado, stall, idex_flush,
             fwd_count, stall_count
   );

   modport slave (
      output freeze, id_valid, id_rs, id_rt, id_uses_rt,
             ex_dest, ex_regwrite, ex_memread, ex_alu_result, wb_data,
      input  memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt,
             memAdeltantado, wbAdelantado, stall, idex_flush,
             fwd_count, stall_count
   );
endinterface

// File: rtl/forwarding_hazard_unit_stall_fsm.sv
// Load-use stall sequencer: holds PC/IF-ID and bubbles ID/EX for STALL_CYCLES.
module hazard_stall_fsm
   import forwarding_hazard_unit_pkg::*;
#(parameter int STALL_CYCLES = 1)
(
   input  logic clk,
   input  logic reset_n,
   input  logic freeze,
   input  logic haz,
   output logic stall,
   output logic idex_flush
);
   stall_state_e state_q, state_d;
   logic [2:0]   cnt_q, cnt_d;
   logic         stall_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
      case (state_q)
         IDLE: begin
            // The first stall cycle is the detection cycle itself.
            if (haz) begin
               stall_raw = 1'b1;
               if (STALL_CYCLES > 1) begin
                  state_d = STALL;
                  cnt_d   = 3'(STALL_CYCLES - 1);
               end
            end
         end
         STALL: begin
            stall_raw = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (freeze) begin
         state_d = state_q;
         cnt_d   = cnt_q;
      end
   end

   // Gated by reset so a live hazard on the inputs cannot hold stall high in reset.
   assign stall      = stall_raw & reset_n;
   assign idex_flush = stall_raw & reset_n;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// EXE-stage forwarding producer: tracks EX/MEM/WB destinations, drives the
// forward selects/data and the load-use stall, plus saturating statistics.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
)
(
   input logic                clk,
   input logic                reset_n,
   forwarding_hazard_unit_if.master fh
);
   logic [REG_W-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic [REG_W-1:0]  mem_dest_q, wb_dest_q;
   logic              mem_rw_q, mem_mr_q, wb_rw_q;
   logic [DATA_W-1:0] mem_data_q;
   logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;
   logic              mem_fwd_rs, mem_fwd_rt, wb_fwd_rs, wb_fwd_rt, any_fwd;
   logic              haz, stall, idex_flush;

   assign haz = fh.id_valid & fh.ex_memread & fh.ex_regwrite & (fh.ex_dest != REG_ZERO) &
                ((fh.ex_dest == fh.id_rs) | (fh.id_uses_rt & (fh.ex_dest == fh.id_rt)));

   hazard_stall_fsm #(.STALL_CYCLES(STALL_CYCLES)) u_stall_fsm (
      .clk        (clk),
      .reset_n    (reset_n),
      .freeze     (fh.freeze),
      .haz        (haz),
      .stall      (stall),
      .idex_flush (idex_flush)
   );

   // A bubble entering EX carries no sources so it can never pick up a forward.
   assign ex_rs_d = (idex_flush | ~fh.id_valid) ? REG_ZERO : fh.id_rs;
   assign ex_rt_d = (idex_flush | ~fh.id_valid) ? REG_ZERO : fh.id_rt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         mem_dest_q <= '0;
         mem_rw_q   <= 1'b0;
         mem_mr_q   <= 1'b0;
         mem_data_q <= '0;
         wb_dest_q  <= '0;
         wb_rw_q    <= 1'b0;
         fwd_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else if (!fh.freeze) begin
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         mem_dest_q <= fh.ex_dest;
         mem_rw_q   <= fh.ex_regwrite;
         mem_mr_q   <= fh.ex_memread;
         mem_data_q <= fh.ex_alu_result;
         wb_dest_q  <= mem_dest_q;
         wb_rw_q    <= mem_rw_q;
         fwd_cnt_q  <= fwd_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // A load in MEM has no data yet; the younger MEM producer wins over WB.
   assign mem_fwd_rs = fwd_hit(mem_rw_q & ~mem_mr_q, mem_dest_q, ex_rs_q);
   assign mem_fwd_rt = fwd_hit(mem_rw_q & ~mem_mr_q, mem_dest_q, ex_rt_q);
   assign wb_fwd_rs  = fwd_hit(wb_rw_q, wb_dest_q, ex_rs_q) & ~mem_fwd_rs;
   assign wb_fwd_rt  = fwd_hit(wb_rw_q, wb_dest_q, ex_rt_q) & ~mem_fwd_rt;
   assign any_fwd    = mem_fwd_rs | mem_fwd_rt | wb_fwd_rs | wb_fwd_rt;

   assign fwd_cnt_d   = (any_fwd && (fwd_cnt_q != '1))   ? fwd_cnt_q + 1'b1   : fwd_cnt_q;
   assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

   assign fh.memAdelant_rs  = mem_fwd_rs;
   assign fh.memAdelant_rt  = mem_fwd_rt;
   assign fh.wbAdelant_rs   = wb_fwd_rs;
   assign fh.wbAdelant_rt   = wb_fwd_rt;
   assign fh.memAdeltantado = mem_data_q;
   assign fh.wbAdelantado   = fh.wb_data;
   assign fh.stall          = stall;
   assign fh.idex_flush     = idex_flush;
   assign fh.fwd_count      = fwd_cnt_q;
   assign fh.stall_count    = stall_cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: dut1 (1-cycle stall, 16-bit counters) and dut3 (3-cycle stall,
// 4-bit counters) share one stimulus stream.
module tb_forwarding_hazard_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   forwarding_hazard_unit_if #(.CNT_W(16)) ifa ();
   forwarding_hazard_unit_if #(.CNT_W(4))  ifb ();

   assign ifb.freeze        = ifa.freeze;
   assign ifb.id_valid      = ifa.id_valid;
   assign ifb.id_rs         = ifa.id_rs;
   assign ifb.id_rt         = ifa.id_rt;
   assign ifb.id_uses_rt    = ifa.id_uses_rt;
   assign ifb.ex_dest       = ifa.ex_dest;
   assign ifb.ex_regwrite   = ifa.ex_regwrite;
   assign ifb.ex_memread    = ifa.ex_memread;
   assign ifb.ex_alu_result = ifa.ex_alu_result;
   assign ifb.wb_data       = ifa.wb_data;

   forwarding_hazard_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .reset_n(reset_n), .fh(ifa));
   forwarding_hazard_unit #(.STALL_CYCLES(3), .CNT_W(4))  dut3 (.clk(clk), .reset_n(reset_n), .fh(ifb));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [4:0] dest, input logic rw, input logic mr, input logic [31:0] alu);
      ifa.ex_dest = dest; ifa.ex_regwrite = rw; ifa.ex_memread = mr; ifa.ex_alu_result = alu;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt);
      ifa.id_valid = v; ifa.id_rs = rs; ifa.id_rt = rt; ifa.id_uses_rt = urt;
   endtask

   task automatic idle();
      set_ex(5'd0, 1'b0, 1'b0, 32'h0);
      set_id(1'b0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifa.freeze = 1'b0;
      ifa.wb_data = 32'h0;
      idle();
      #2;
      chk("rst_stall", {31'b0, ifa.stall}, 32'd0);
      chk("rst_flags", {28'b0, ifa.memAdelant_rs, ifa.memAdelant_rt, ifa.wbAdelant_rs, ifa.wbAdelant_rt}, 32'd0);
      chk("rst_memdata", ifa.memAdeltantado, 32'h0);
      chk("rst_counts", {ifa.fwd_count, ifa.stall_count}, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      step();

      // back-to-back ALU dependency
      set_id(1'b1, 5'd3, 5'd4, 1'b1);
      set_ex(5'd3, 1'b1, 1'b0, 32'h0000_0010);
      step(); #1;
      chk("b2b_mem_rs", {31'b0, ifa.memAdelant_rs}, 32'd1);
      chk("b2b_mem_data", ifa.memAdeltantado, 32'h10);
      chk("b2b_wb_rs", {31'b0, ifa.wbAdelant_rs}, 32'd0);
      chk("b2b_mem_rt", {31'b0, ifa.memAdelant_rt}, 32'd0);
      idle();
      step();
      chk("b2b_fwd_count", {16'b0, ifa.fwd_count}, 32'd1);
      step(); step();

      // distance-2 dependency through WB
      set_ex(5'd5, 1'b1, 1'b0, 32'h55);
      step();
      set_ex(5'd6, 1'b1, 1'b0, 32'h66);
      set_id(1'b1, 5'd1, 5'd5, 1'b1);
      ifa.wb_data = 32'hDEAD_BEEF;
      step(); #1;
      chk("d2_wb_rt", {31'b0, ifa.wbAdelant_rt}, 32'd1);
      chk("d2_mem_rt", {31'b0, ifa.memAdelant_rt}, 32'd0);
      chk("d2_wb_rs", {31'b0, ifa.wbAdelant_rs}, 32'd0);
      chk("d2_wb_data", ifa.wbAdelantado, 32'hDEAD_BEEF);
      chk("d2_mem_data", ifa.memAdeltantado, 32'h66);
      idle();
      step();
      chk("d2_fwd_count", {16'b0, ifa.fwd_count}, 32'd2);
      step();

      // load-use with a single stall cycle
      set_ex(5'd4, 1'b1, 1'b1, 32'h1000);
      set_id(1'b1, 5'd4, 5'd0, 1'b0);
      #1;
      chk("lu1_stall", {31'b0, ifa.stall}, 32'd1);
      chk("lu1_flush", {31'b0, ifa.idex_flush}, 32'd1);
      step();
      set_ex(5'd0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("lu1_stall_done", {30'b0, ifa.stall, ifa.idex_flush}, 32'd0);
      step(); #1;
      chk("lu1_wb_rs", {31'b0, ifa.wbAdelant_rs}, 32'd1);
      chk("lu1_mem_rs", {31'b0, ifa.memAdelant_rs}, 32'd0);
      chk("lu1_stall_count", {16'b0, ifa.stall_count}, 32'd1);
      idle();
      step(); step(); step();

      // double hit: MEM beats WB; $0 never forwards
      set_ex(5'd7, 1'b1, 1'b0, 32'h77);
      step();
      set_ex(5'd7, 1'b1, 1'b0, 32'h78);
      set_id(1'b1, 5'd7, 5'd0, 1'b0);
      step(); #1;
      chk("dbl_mem_rs", {31'b0, ifa.memAdelant_rs}, 32'd1);
      chk("dbl_wb_rs", {31'b0, ifa.wbAdelant_rs}, 32'd0);
      chk("dbl_mem_data", ifa.memAdeltantado, 32'h78);
      set_ex(5'd0, 1'b1, 1'b0, 32'h99);
      set_id(1'b1, 5'd0, 5'd0, 1'b1);
      step(); step(); #1;
      chk("r0_flags", {28'b0, ifa.memAdelant_rs, ifa.memAdelant_rt, ifa.wbAdelant_rs, ifa.wbAdelant_rt}, 32'd0);
      chk("r0_fwd_count", {16'b0, ifa.fwd_count}, 32'd4);
      chk("r0_stall_count", {16'b0, ifa.stall_count}, 32'd1);
      idle();
      step();

      // three-cycle stall stretched by a freeze pulse
      set_ex(5'd4, 1'b1, 1'b1, 32'h2000);
      set_id(1'b1, 5'd4, 5'd0, 1'b0);
      #1;
      chk("lu3_c0_stall", {30'b0, ifb.stall, ifb.idex_flush}, 32'd3);
      step();
      set_ex(5'd0, 1'b0, 1'b0, 32'h0);
      ifa.freeze = 1'b1;
      #1;
      chk("lu3_c1_stall", {31'b0, ifb.stall}, 32'd1);
      step();
      ifa.freeze = 1'b0;
      #1;
      chk("lu3_c1f_stall", {31'b0, ifb.stall}, 32'd1);
      chk("lu3_frz_count", {16'b0, ifa.stall_count}, 32'd2);
      step(); #1;
      chk("lu3_c2_stall", {31'b0, ifb.stall}, 32'd1);
      step(); #1;
      chk("lu3_end_stall", {30'b0, ifb.stall, ifb.idex_flush}, 32'd0);

      // asynchronous reset in the middle of a stall
      set_ex(5'd4, 1'b1, 1'b1, 32'h3000);
      #1;
      chk("rs_c0_stall", {31'b0, ifb.stall}, 32'd1);
      step();
      set_ex(5'd0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rs_c1_stall", {31'b0, ifb.stall}, 32'd1);
      #2; reset_n = 1'b0; #1;
      chk("rs_async_drop", {30'b0, ifb.stall, ifb.idex_flush}, 32'd0);
      chk("rs_counts", {8'b0, ifb.stall_count, ifb.fwd_count, ifa.fwd_count}, 32'd0);
      idle();
      #2; reset_n = 1'b1;
      step(); #1;
      chk("rs_idle_after", {31'b0, ifb.stall}, 32'd0);

      // saturation of the 4-bit counter vs the 16-bit one
      set_ex(5'd9, 1'b1, 1'b0, 32'h9);
      set_id(1'b1, 5'd9, 5'd0, 1'b0);
      repeat (10) step();
      chk("sat_cnt9", {28'b0, ifb.fwd_count}, 32'd9);
      repeat (6) step();
      chk("sat_cnt15", {28'b0, ifb.fwd_count}, 32'hF);
      repeat (5) step();
      chk("sat_hold", {28'b0, ifb.fwd_count}, 32'hF);
      chk("sat_wide20", {16'b0, ifa.fwd_count}, 32'd20);
      step();
      chk("sat_hold2", {28'b0, ifb.fwd_count}, 32'hF);
      chk("sat_wide21", {16'b0, ifa.fwd_count}, 32'd21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
